// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder
//   Buffers outbound bytes in a synchronous FIFO and hands them to the uart_tx
//   byte transmitter one at a time. Baud-divisor updates are captured and only
//   issued between frames, ahead of any queued byte.
//
// Ports
//   clk, reset            single clock, synchronous active-high reset
//   wr_data, wr_en        byte push from the core (ignored when full)
//   full, empty, level    registered FIFO status, level in 0..DEPTH
//   cfg_data, cfg_wr      new cycles_per_bit value, update request
//   cfg_pending           divisor captured but not yet issued
//   err_clr               clears the sticky error flags
//   overflow, tx_lost     sticky: push while full / busy never rose after send
//   tx_data, tx_send,     to uart_tx data/send/set
//   tx_set
//   tx_busy               from uart_tx busy
module uart_tx_feeder #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned AW           = 4,
    parameter int unsigned BUSY_TIMEOUT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    wr_data,
    input  logic          wr_en,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    input  logic [12:0]   cfg_data,
    input  logic          cfg_wr,
    output logic          cfg_pending,
    input  logic          err_clr,
    output logic          overflow,
    output logic          tx_lost,
    output logic [12:0]   tx_data,
    output logic          tx_send,
    output logic          tx_set,
    input  logic          tx_busy
);

    localparam int unsigned CW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CW-1:0] CntLast = CW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StSet, StWaitBusy, StWaitDone} state_t;

    state_t          state;
    logic [7:0]      mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     level_next;
    logic [12:0]     cfg_div;
    logic [CW-1:0]   busy_cnt;

    logic push;
    logic issue_set;
    logic issue_send;
    logic lost_now;

    // Divisor updates take priority over data so a new rate applies to the
    // very next frame.
    always_comb begin
        push       = wr_en && !full;
        issue_set  = (state == StIdle) && !tx_busy && cfg_pending;
        issue_send = (state == StIdle) && !tx_busy && !cfg_pending && !empty;
        lost_now   = (state == StWaitBusy) && !tx_busy && (busy_cnt == CntLast);
    end

    always_comb begin
        level_next = level;
        if (push && !issue_send) begin
            level_next = level + 1'b1;
        end else if (!push && issue_send) begin
            level_next = level - 1'b1;
        end
    end

    // FIFO pointers, occupancy and flags; full/empty follow level on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (issue_send) begin
                rptr <= rptr + 1'b1;
            end
            level <= level_next;
            full  <= (level_next == (AW + 1)'(DEPTH));
            empty <= (level_next == '0);
            // full is the pre-edge value, so a same-cycle pop does not save the byte
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (err_clr) begin
                overflow <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= StIdle;
            tx_data     <= '0;
            tx_send     <= 1'b0;
            tx_set      <= 1'b0;
            cfg_pending <= 1'b0;
            cfg_div     <= '0;
            tx_lost     <= 1'b0;
            busy_cnt    <= '0;
        end else begin
            // Both strobes default low, which makes every pulse one cycle wide.
            tx_send <= 1'b0;
            tx_set  <= 1'b0;

            case (state)
                StIdle: begin
                    if (issue_set) begin
                        tx_set  <= 1'b1;
                        tx_data <= cfg_div;
                        state   <= StSet;
                    end else if (issue_send) begin
                        tx_send  <= 1'b1;
                        tx_data  <= {5'b0, mem[rptr]};
                        busy_cnt <= '0;
                        state    <= StWaitBusy;
                    end
                end
                StSet: begin
                    state <= StIdle;
                end
                StWaitBusy: begin
                    if (tx_busy) begin
                        state <= StWaitDone;
                    end else if (lost_now) begin
                        state <= StIdle;
                    end else begin
                        busy_cnt <= busy_cnt + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!tx_busy) begin
                        state <= StIdle;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            // A fresh request on the issuing edge re-arms with the new value.
            if (cfg_wr) begin
                cfg_pending <= 1'b1;
                cfg_div     <= cfg_data;
            end else if (issue_set) begin
                cfg_pending <= 1'b0;
            end

            if (lost_now) begin
                tx_lost <= 1'b1;
            end else if (err_clr) begin
                tx_lost <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Directed bench for uart_tx_feeder with a behavioural uart_tx stand-in.
module tb_uart_tx_feeder;

    localparam int unsigned DEPTH        = 16;
    localparam int unsigned AW           = 4;
    localparam int unsigned BUSY_TIMEOUT = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    wr_data = '0;
    logic          wr_en = 1'b0;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic [12:0]   cfg_data = '0;
    logic          cfg_wr = 1'b0;
    logic          cfg_pending;
    logic          err_clr = 1'b0;
    logic          overflow;
    logic          tx_lost;
    logic [12:0]   tx_data;
    logic          tx_send;
    logic          tx_set;
    logic          tx_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_feeder #(
        .DEPTH       (DEPTH),
        .AW          (AW),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .full       (full),
        .empty      (empty),
        .level      (level),
        .cfg_data   (cfg_data),
        .cfg_wr     (cfg_wr),
        .cfg_pending(cfg_pending),
        .err_clr    (err_clr),
        .overflow   (overflow),
        .tx_lost    (tx_lost),
        .tx_data    (tx_data),
        .tx_send    (tx_send),
        .tx_set     (tx_set),
        .tx_busy    (tx_busy)
    );

    // uart_tx stand-in: bit period is cycles_per_bit+1, frame = start, 8 data LSB first, stop.
    logic          tie_low = 1'b0;
    logic          busy_m;
    logic          line;
    logic [12:0]   cpb_m;
    logic [9:0]    shreg;
    int            tick;
    int            bitcnt;

    assign tx_busy = busy_m && !tie_low;

    always @(posedge clk) begin
        if (reset) begin
            busy_m <= 1'b0;
            line   <= 1'b1;
            cpb_m  <= 13'd3;
            tick   <= 0;
            bitcnt <= 0;
            shreg  <= '1;
        end else if (!busy_m) begin
            if (tx_set) begin
                cpb_m <= tx_data;
            end else if (tx_send && !tie_low) begin
                busy_m <= 1'b1;
                shreg  <= {1'b1, tx_data[7:0], 1'b0};
                line   <= 1'b0;
                tick   <= 0;
                bitcnt <= 0;
            end
        end else begin
            if (tick == int'(cpb_m)) begin
                tick <= 0;
                if (bitcnt == 9) begin
                    busy_m <= 1'b0;
                    line   <= 1'b1;
                end else begin
                    bitcnt <= bitcnt + 1;
                    line   <= shreg[bitcnt + 1];
                end
            end else begin
                tick <= tick + 1;
            end
        end
    end

    // Event log of strobes ({is_set, tx_data}) and a strobe-shape violation count.
    logic [13:0] ev_q[$];
    int          viol = 0;
    logic        prev_send = 1'b0;
    logic        prev_set = 1'b0;

    always @(negedge clk) begin
        if (tx_send) ev_q.push_back({1'b0, tx_data});
        if (tx_set) ev_q.push_back({1'b1, tx_data});
        if ((tx_send && tx_set) || (tx_send && prev_send) || (tx_set && prev_set)) begin
            viol <= viol + 1;
        end
        prev_send <= tx_send;
        prev_set  <= tx_set;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        wr_data = b;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    task automatic wait_busy(input int maxc);
        int n = 0;
        while (!tx_busy && n < maxc) begin
            step();
            n++;
        end
        checks++;
        if (!tx_busy) begin
            failures++;
            $display("FAIL wait_busy timeout got_busy=%0b after=%0d cycles", tx_busy, n);
        end
    endtask

    task automatic wait_quiet(input int maxc);
        int q = 0;
        int n = 0;
        while (q < 4 && n < maxc) begin
            step();
            n++;
            if (empty && !tx_busy && !tx_send && !tx_set) q++;
            else q = 0;
        end
        checks++;
        if (q < 4) begin
            failures++;
            $display("FAIL wait_quiet timeout got_cycles=%0d limit=%0d", n, maxc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        checks += 9;
        if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%0b exp=0", full); end
        if (empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", empty); end
        if (level !== 5'd0) begin failures++; $display("FAIL reset_level got=%0d exp=0", level); end
        if (cfg_pending !== 1'b0) begin failures++; $display("FAIL reset_cfg_pending got=%0b exp=0", cfg_pending); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        if (tx_lost !== 1'b0) begin failures++; $display("FAIL reset_tx_lost got=%0b exp=0", tx_lost); end
        if (tx_data !== 13'd0) begin failures++; $display("FAIL reset_tx_data got=%0h exp=0", tx_data); end
        if (tx_send !== 1'b0) begin failures++; $display("FAIL reset_tx_send got=%0b exp=0", tx_send); end
        if (tx_set !== 1'b0) begin failures++; $display("FAIL reset_tx_set got=%0b exp=0", tx_set); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [9:0] exp_line;
        exp_line = {1'b1, 8'h55, 1'b0};
        ev_q.delete();
        push_byte(8'h55);
        checks += 3;
        if (tx_send !== 1'b0) begin failures++; $display("FAIL single_send_e0 got=%0b exp=0", tx_send); end
        if (level !== 5'd1) begin failures++; $display("FAIL single_level_e0 got=%0d exp=1", level); end
        if (empty !== 1'b0) begin failures++; $display("FAIL single_empty_e0 got=%0b exp=0", empty); end
        step();
        checks += 3;
        if (tx_send !== 1'b1) begin failures++; $display("FAIL single_send_e1 got=%0b exp=1", tx_send); end
        if (tx_data !== 13'h0055) begin failures++; $display("FAIL single_data_e1 got=%0h exp=55", tx_data); end
        if (empty !== 1'b1) begin failures++; $display("FAIL single_empty_pop got=%0b exp=1", empty); end
        step();
        checks++;
        if (tx_send !== 1'b0) begin failures++; $display("FAIL single_send_e2 got=%0b exp=0", tx_send); end
        repeat (2) step();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (line !== exp_line[k]) begin
                failures++;
                $display("FAIL single_line_bit%0d got=%0b exp=%0b", k, line, exp_line[k]);
            end
            if (k < 9) repeat (4) step();
        end
        wait_quiet(200);
        checks += 2;
        if (tx_data !== 13'h0055) begin failures++; $display("FAIL single_data_hold got=%0h exp=55", tx_data); end
        if (ev_q.size() != 1) begin failures++; $display("FAIL single_send_count got=%0d exp=1", ev_q.size()); end
    endtask

    task automatic test_fill();
        logic [13:0] got;
        logic [13:0] exp;
        ev_q.delete();
        for (int i = 0; i < 16; i++) begin
            wr_data = 8'(i);
            wr_en   = 1'b1;
            step();
            if (i == 1) begin
                checks++;
                if (level !== 5'd1) begin failures++; $display("FAIL fill_push_pop_level got=%0d exp=1", level); end
            end
        end
        checks += 2;
        if (level !== 5'd15) begin failures++; $display("FAIL fill_level16 got=%0d exp=15", level); end
        if (full !== 1'b0) begin failures++; $display("FAIL fill_full16 got=%0b exp=0", full); end
        wr_data = 8'hAA;
        step();
        checks += 3;
        if (level !== 5'd16) begin failures++; $display("FAIL fill_level17 got=%0d exp=16", level); end
        if (full !== 1'b1) begin failures++; $display("FAIL fill_full17 got=%0b exp=1", full); end
        if (overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf17 got=%0b exp=0", overflow); end
        wr_data = 8'hBB;
        step();
        checks += 2;
        if (overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf18 got=%0b exp=1", overflow); end
        if (level !== 5'd16) begin failures++; $display("FAIL fill_level18 got=%0d exp=16", level); end
        wr_data = 8'hCC;
        err_clr = 1'b1;
        step();
        wr_en = 1'b0;
        checks++;
        if (overflow !== 1'b1) begin failures++; $display("FAIL fill_ovf_set_wins got=%0b exp=1", overflow); end
        step();
        err_clr = 1'b0;
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL fill_ovf_clear got=%0b exp=0", overflow); end
        wait_quiet(2000);
        checks++;
        if (ev_q.size() != 17) begin failures++; $display("FAIL fill_send_count got=%0d exp=17", ev_q.size()); end
        for (int i = 0; i < 17; i++) begin
            exp = (i < 16) ? 14'(i) : 14'h00AA;
            got = (i < ev_q.size()) ? ev_q[i] : '1;
            checks++;
            if (got !== exp) begin failures++; $display("FAIL fill_order%0d got=%0h exp=%0h", i, got, exp); end
        end
    endtask

    task automatic test_cfg();
        int n;
        int low_len;
        logic dropped;
        ev_q.delete();
        push_byte(8'h10);
        push_byte(8'h01);
        wait_busy(20);
        cfg_data = 13'h0004;
        cfg_wr   = 1'b1;
        step();
        cfg_wr = 1'b0;
        checks++;
        if (cfg_pending !== 1'b1) begin failures++; $display("FAIL cfg_pending_set got=%0b exp=1", cfg_pending); end
        n = 0;
        dropped = 1'b0;
        while (tx_busy && n < 200) begin
            step();
            n++;
            if (tx_busy && (cfg_pending !== 1'b1 || tx_set !== 1'b0)) dropped = 1'b1;
        end
        checks++;
        if (dropped !== 1'b0) begin failures++; $display("FAIL cfg_held_mid_frame got=%0b exp=0", dropped); end
        n = 0;
        while (line !== 1'b0 && n < 50) begin
            step();
            n++;
        end
        low_len = 0;
        while (line === 1'b0 && low_len < 50) begin
            low_len++;
            step();
        end
        checks++;
        if (low_len != 5) begin failures++; $display("FAIL cfg_bit_period got=%0d exp=5", low_len); end
        wait_quiet(300);
        checks += 4;
        if (ev_q.size() != 3) begin failures++; $display("FAIL cfg_event_count got=%0d exp=3", ev_q.size()); end
        if (ev_q.size() >= 3) begin
            if (ev_q[0] !== 14'h0010) begin failures++; $display("FAIL cfg_ev0 got=%0h exp=10", ev_q[0]); end
            if (ev_q[1] !== 14'h2004) begin failures++; $display("FAIL cfg_ev1_set got=%0h exp=2004", ev_q[1]); end
            if (ev_q[2] !== 14'h0001) begin failures++; $display("FAIL cfg_ev2 got=%0h exp=1", ev_q[2]); end
        end else begin
            failures += 3;
            $display("FAIL cfg_events_missing got=%0d exp=3", ev_q.size());
        end
    endtask

    task automatic test_last_wins();
        ev_q.delete();
        push_byte(8'h02);
        wait_busy(20);
        cfg_data = 13'h0010;
        cfg_wr   = 1'b1;
        step();
        cfg_data = 13'h0020;
        step();
        cfg_wr = 1'b0;
        wait_quiet(300);
        checks += 2;
        if (ev_q.size() != 2) begin failures++; $display("FAIL last_event_count got=%0d exp=2", ev_q.size()); end
        if (ev_q.size() < 2 || ev_q[1] !== 14'h2020) begin
            failures++;
            $display("FAIL last_set_value got=%0h exp=2020", (ev_q.size() >= 2) ? ev_q[1] : 14'h0);
        end
        checks++;
        if (cfg_pending !== 1'b0) begin failures++; $display("FAIL last_pending_clr got=%0b exp=0", cfg_pending); end
        cfg_data = 13'h0003;
        cfg_wr   = 1'b1;
        step();
        cfg_wr = 1'b0;
        wait_quiet(50);
    endtask

    task automatic test_lost();
        ev_q.delete();
        tie_low = 1'b1;
        push_byte(8'h33);
        step();
        checks += 2;
        if (tx_send !== 1'b1) begin failures++; $display("FAIL lost_send got=%0b exp=1", tx_send); end
        if (tx_data !== 13'h0033) begin failures++; $display("FAIL lost_data got=%0h exp=33", tx_data); end
        step();
        checks++;
        if (tx_send !== 1'b0) begin failures++; $display("FAIL lost_send_width got=%0b exp=0", tx_send); end
        step();
        step();
        checks++;
        if (tx_lost !== 1'b0) begin failures++; $display("FAIL lost_early got=%0b exp=0", tx_lost); end
        step();
        checks += 2;
        if (tx_lost !== 1'b1) begin failures++; $display("FAIL lost_set got=%0b exp=1", tx_lost); end
        if (ev_q.size() != 1) begin failures++; $display("FAIL lost_send_count got=%0d exp=1", ev_q.size()); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (tx_lost !== 1'b0) begin failures++; $display("FAIL lost_clear got=%0b exp=0", tx_lost); end
        push_byte(8'h44);
        step();
        checks++;
        if (tx_send !== 1'b1) begin failures++; $display("FAIL lost_back_to_idle got=%0b exp=1", tx_send); end
        repeat (3) step();
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (tx_lost !== 1'b1) begin failures++; $display("FAIL lost_set_wins got=%0b exp=1", tx_lost); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        checks++;
        if (tx_lost !== 1'b0) begin failures++; $display("FAIL lost_clear2 got=%0b exp=0", tx_lost); end
        tie_low = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(8'h61 + i);
            wr_en   = 1'b1;
            step();
        end
        wr_en = 1'b0;
        wait_busy(20);
        cfg_data = 13'h0007;
        cfg_wr   = 1'b1;
        step();
        cfg_wr = 1'b0;
        checks += 2;
        if (level !== 5'd5) begin failures++; $display("FAIL rmid_level_pre got=%0d exp=5", level); end
        if (cfg_pending !== 1'b1) begin failures++; $display("FAIL rmid_pending_pre got=%0b exp=1", cfg_pending); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks += 6;
        if (level !== 5'd0) begin failures++; $display("FAIL rmid_level got=%0d exp=0", level); end
        if (empty !== 1'b1) begin failures++; $display("FAIL rmid_empty got=%0b exp=1", empty); end
        if (full !== 1'b0) begin failures++; $display("FAIL rmid_full got=%0b exp=0", full); end
        if (tx_send !== 1'b0) begin failures++; $display("FAIL rmid_send got=%0b exp=0", tx_send); end
        if (tx_set !== 1'b0) begin failures++; $display("FAIL rmid_set got=%0b exp=0", tx_set); end
        if (cfg_pending !== 1'b0) begin failures++; $display("FAIL rmid_pending got=%0b exp=0", cfg_pending); end
        ev_q.delete();
        repeat (10) step();
        checks++;
        if (ev_q.size() != 0) begin failures++; $display("FAIL rmid_no_strobes got=%0d exp=0", ev_q.size()); end
    endtask

    task automatic test_strobes();
        checks++;
        if (viol != 0) begin failures++; $display("FAIL strobe_shape got=%0d exp=0", viol); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_cfg();
        test_last_wins();
        test_lost();
        test_reset_mid();
        test_strobes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
